// File: rtl/board_pixel_pipe.sv
// board_pixel_pipe: two-stage pixel generator for the battleship display.
// Stage 0 classifies the incoming coordinate and presents the cell address;
// the board answers with cell_val one strobe later, when stage 1 picks the colour.
module board_pixel_pipe #(
   parameter int unsigned N          = 5,
   parameter int unsigned CELL_LOG2  = 5,
   parameter int unsigned X0_E       = 64,
   parameter int unsigned X0_P       = 416,
   parameter int unsigned Y0         = 160,
   parameter bit          SHOW_ENEMY = 1'b0,
   parameter int unsigned BLINK_FRM  = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic [9:0] next_x,
   input  logic [9:0] next_y,
   output logic       cell_sel,
   output logic [2:0] cell_row,
   output logic [2:0] cell_col,
   input  logic [2:0] cell_val,
   input  logic [2:0] cursor_x,
   input  logic [2:0] cursor_y,
   input  logic       cursor_en,
   output logic [7:0] pixel_color,
   output logic       pixel_valid
);

   localparam int unsigned CELL  = 1 << CELL_LOG2;
   localparam int unsigned SPAN  = N << CELL_LOG2;
   localparam int unsigned FRM_W = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;

   typedef logic [CELL_LOG2-1:0] off_t;
   typedef enum logic [2:0] {ClsOff, ClsBg, ClsSep, ClsEnemy, ClsPlayer} cls_e;

   // Stage-0 combinational terms
   int unsigned xu;
   int unsigned yu;
   int unsigned x_org;
   logic        is_off;
   logic        is_sep;
   logic        in_y;
   logic        in_e;
   logic        in_p;
   cls_e        cls_d;
   off_t        off_x_d;
   off_t        off_y_d;
   logic [2:0]  row_d;
   logic [2:0]  col_d;
   logic        cur_d;

   // Stage-0 registers
   logic        s0_vld_q;
   cls_e        cls_q;
   off_t        off_x_q;
   off_t        off_y_q;
   logic        cur_q;

   // Frame / blink state
   logic             frame_start;
   logic [FRM_W-1:0] frm_q;
   logic             blink_q;

   // Stage-1 decode
   logic [7:0] cell_color;
   logic [7:0] color_d;
   logic       valid_d;

   // The cursor ring is two pixels thick just inside each cell edge.
   function automatic logic on_border(input off_t o);
      return (o == off_t'(1)) || (o == off_t'(2)) ||
             (o == off_t'(CELL - 2)) || (o == off_t'(CELL - 1));
   endfunction

   // Classify the incoming coordinate and form cell address, offsets and cursor hit.
   always_comb begin
      xu      = 32'(next_x);
      yu      = 32'(next_y);
      is_off  = (xu >= 32'd640) || (yu >= 32'd480);
      is_sep  = (xu >= 32'd288) && (xu <= 32'd351);
      in_y    = (yu >= Y0) && (yu < Y0 + SPAN);
      in_e    = in_y && (xu >= X0_E) && (xu < X0_E + SPAN);
      in_p    = in_y && (xu >= X0_P) && (xu < X0_P + SPAN);
      x_org   = in_e ? X0_E : X0_P;
      off_x_d = off_t'(xu - x_org);
      off_y_d = off_t'(yu - Y0);
      row_d   = 3'((yu - Y0) >> CELL_LOG2);
      col_d   = 3'((xu - x_org) >> CELL_LOG2);
      // Boards take precedence over the separator band.
      if (is_off) begin
         cls_d = ClsOff;
      end else if (in_e) begin
         cls_d = ClsEnemy;
      end else if (in_p) begin
         cls_d = ClsPlayer;
      end else if (is_sep) begin
         cls_d = ClsSep;
      end else begin
         cls_d = ClsBg;
      end
      cur_d = in_e && cursor_en && blink_q &&
              (32'(cursor_x) < N) && (32'(cursor_y) < N) &&
              (row_d == cursor_y) && (col_d == cursor_x) &&
              (on_border(off_x_d) || on_border(off_y_d));
   end

   // Stage-0 capture: pixel attributes and the board read address, in one strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_vld_q <= 1'b0;
         cls_q    <= ClsOff;
         off_x_q  <= '0;
         off_y_q  <= '0;
         cur_q    <= 1'b0;
         cell_sel <= 1'b0;
         cell_row <= '0;
         cell_col <= '0;
      end else if (pix_en) begin
         s0_vld_q <= 1'b1;
         cls_q    <= cls_d;
         off_x_q  <= off_x_d;
         off_y_q  <= off_y_d;
         cur_q    <= cur_d;
         if ((cls_d == ClsEnemy) || (cls_d == ClsPlayer)) begin
            cell_sel <= (cls_d == ClsPlayer);
            cell_row <= row_d;
            cell_col <= col_d;
         end else begin
            cell_sel <= 1'b0;
            cell_row <= '0;
            cell_col <= '0;
         end
      end
   end

   assign frame_start = pix_en && (next_x == 10'd0) && (next_y == 10'd0);

   // Count frame starts; the blink phase flips every BLINK_FRM frames.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frm_q   <= '0;
         blink_q <= 1'b0;
      end else if (frame_start) begin
         if (frm_q == FRM_W'(BLINK_FRM - 1)) begin
            frm_q   <= '0;
            blink_q <= ~blink_q;
         end else begin
            frm_q <= frm_q + 1'b1;
         end
      end
   end

   // Map the returned cell code to its colour; enemy ships stay hidden unless shown.
   always_comb begin
      cell_color = 8'h92;
      unique case (cell_val)
         3'd0:    cell_color = 8'h1F;
         3'd6:    cell_color = 8'hB0;
         3'd7:    cell_color = 8'hF0;
         default: cell_color = ((cls_q == ClsEnemy) && !SHOW_ENEMY) ? 8'h1F : 8'h92;
      endcase
   end

   // Resolve the per-pixel priority: off, separator, background, grid, cursor, cell.
   always_comb begin
      color_d = 8'h00;
      valid_d = s0_vld_q;
      case (cls_q)
         ClsOff: valid_d = 1'b0;
         ClsSep: color_d = 8'h00;
         ClsBg:  color_d = 8'hFF;
         ClsEnemy, ClsPlayer: begin
            if ((off_x_q == '0) || (off_y_q == '0)) begin
               color_d = 8'h00;
            end else if (cur_q) begin
               color_d = 8'hFC;
            end else begin
               color_d = cell_color;
            end
         end
         default: valid_d = 1'b0;
      endcase
   end

   // Output register, loaded on the second strobe after the coordinate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_color <= 8'h00;
         pixel_valid <= 1'b0;
      end else if (pix_en) begin
         pixel_color <= color_d;
         pixel_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_board_pixel_pipe.sv
// tb_board_pixel_pipe: directed stimulus with a coordinate-level reference model.
module tb_board_pixel_pipe;

   localparam int N    = 5;
   localparam int CELL = 32;
   localparam int X0E  = 64;
   localparam int X0P  = 416;
   localparam int Y0   = 160;
   localparam int BF   = 30;
   localparam bit SHOW = 1'b0;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pix_en = 1'b0;
   logic [9:0] next_x = '0;
   logic [9:0] next_y = '0;
   logic       cell_sel;
   logic [2:0] cell_row;
   logic [2:0] cell_col;
   logic [2:0] cell_val;
   logic [2:0] cursor_x = '0;
   logic [2:0] cursor_y = '0;
   logic       cursor_en = 1'b0;
   logic [7:0] pixel_color;
   logic       pixel_valid;

   logic [2:0] board [0:1][0:7][0:7];

   int checks = 0;
   int failures = 0;
   bit run_cmp = 1'b0;

   board_pixel_pipe #(
      .N(N), .CELL_LOG2(5), .X0_E(X0E), .X0_P(X0P), .Y0(Y0),
      .SHOW_ENEMY(SHOW), .BLINK_FRM(BF)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .next_x(next_x), .next_y(next_y),
      .cell_sel(cell_sel), .cell_row(cell_row), .cell_col(cell_col), .cell_val(cell_val),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
      .pixel_color(pixel_color), .pixel_valid(pixel_valid)
   );

   // Board storage answers the registered address combinationally.
   assign cell_val = board[cell_sel][cell_row][cell_col];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference colour of a screen coordinate from the drawing rules.
   function automatic void model_pix(input int x, input int y, input int cx, input int cy,
                                     input bit ce, input bit bl,
                                     output logic [7:0] c, output bit v);
      bit en;
      bit pl;
      int ox;
      int oy;
      int row;
      int col;
      int code;
      v  = 1'b1;
      c  = 8'h00;
      en = (x >= X0E) && (x < X0E + N * CELL) && (y >= Y0) && (y < Y0 + N * CELL);
      pl = (x >= X0P) && (x < X0P + N * CELL) && (y >= Y0) && (y < Y0 + N * CELL);
      if (x >= 640 || y >= 480) begin
         v = 1'b0;
      end else if (en || pl) begin
         ox  = (x - (en ? X0E : X0P)) % CELL;
         oy  = (y - Y0) % CELL;
         col = (x - (en ? X0E : X0P)) / CELL;
         row = (y - Y0) / CELL;
         if (ox == 0 || oy == 0) begin
            c = 8'h00;
         end else if (en && ce && bl && col == cx && row == cy &&
                      (ox inside {1, 2, CELL - 2, CELL - 1} ||
                       oy inside {1, 2, CELL - 2, CELL - 1})) begin
            c = 8'hFC;
         end else begin
            code = int'(board[en ? 0 : 1][row][col]);
            case (code)
               0:       c = 8'h1F;
               6:       c = 8'hB0;
               7:       c = 8'hF0;
               default: c = (en && !SHOW) ? 8'h1F : 8'h92;
            endcase
         end
      end else if (x >= 288 && x <= 351) begin
         c = 8'h00;
      end else begin
         c = 8'hFF;
      end
   endfunction

   // Model state: one pending coordinate plus the visible output.
   int         m_frm = 0;
   bit         m_blink = 1'b0;
   bit         p_vld = 1'b0;
   int         p_x, p_y, p_cx, p_cy;
   bit         p_ce, p_bl;
   logic [7:0] e_color = 8'h00;
   bit         e_valid = 1'b0;
   bit         e_achk = 1'b1;
   bit         e_sel = 1'b0;
   int         e_row = 0;
   int         e_col = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_frm = 0; m_blink = 1'b0; p_vld = 1'b0;
         e_color = 8'h00; e_valid = 1'b0;
         e_achk = 1'b1; e_sel = 1'b0; e_row = 0; e_col = 0;
      end else if (pix_en) begin
         if (p_vld) model_pix(p_x, p_y, p_cx, p_cy, p_ce, p_bl, e_color, e_valid);
         else begin
            e_color = 8'h00; e_valid = 1'b0;
         end
         p_x = int'(next_x); p_y = int'(next_y);
         p_cx = int'(cursor_x); p_cy = int'(cursor_y);
         p_ce = cursor_en; p_bl = m_blink; p_vld = 1'b1;
         if (p_y >= Y0 && p_y < Y0 + N * CELL && p_x >= X0E && p_x < X0E + N * CELL) begin
            e_achk = 1'b1; e_sel = 1'b0;
            e_row = (p_y - Y0) / CELL; e_col = (p_x - X0E) / CELL;
         end else if (p_y >= Y0 && p_y < Y0 + N * CELL && p_x >= X0P && p_x < X0P + N * CELL)
         begin
            e_achk = 1'b1; e_sel = 1'b1;
            e_row = (p_y - Y0) / CELL; e_col = (p_x - X0P) / CELL;
         end else begin
            e_achk = 1'b0;
         end
         if (p_x == 0 && p_y == 0) begin
            m_frm++;
            if (m_frm == BF) begin
               m_frm = 0; m_blink = !m_blink;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (run_cmp) begin
         chk("cyc_color", 32'(pixel_color), 32'(e_color));
         chk("cyc_valid", 32'(pixel_valid), 32'(e_valid));
         if (e_achk) begin
            chk("cyc_sel", 32'(cell_sel), 32'(e_sel));
            chk("cyc_row", 32'(cell_row), 32'(e_row));
            chk("cyc_col", 32'(cell_col), 32'(e_col));
         end
      end
   end

   task automatic step(input int x, input int y, input bit en);
      @(negedge clk);
      next_x = 10'(x);
      next_y = 10'(y);
      pix_en = en;
   endtask

   // Present one coordinate, then two filler strobes, and check the literal result.
   task automatic probe(input string nm, input int x, input int y,
                        input logic [7:0] c, input bit v);
      step(x, y, 1'b1);
      step(10, 10, 1'b1);
      step(10, 10, 1'b1);
      chk({nm, "_color"}, 32'(pixel_color), 32'(c));
      chk({nm, "_valid"}, 32'(pixel_valid), 32'(v));
   endtask

   int t5_x   [7] = '{97, 300, 700, 449, 10, 10, 10};
   int t5_y   [7] = '{193, 50, 50, 161, 10, 10, 10};
   bit t5_en  [7] = '{1, 0, 0, 1, 1, 1, 1};
   int t5_exp [7] = '{'hFF, 'hFF, 'hFF, 'hFF, 'h1F, 'h92, 'hFF};

   initial begin
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
               board[s][r][c] = 3'd0;

      #2 reset = 1'b0;
      #1;
      chk("rst_color", 32'(pixel_color), 32'h00);
      chk("rst_valid", 32'(pixel_valid), 32'h0);
      chk("rst_row", 32'(cell_row), 32'h0);
      run_cmp = 1'b1;
      @(negedge clk);
      reset = 1'b1;

      // T1: reset mid-stream, then recovery
      step(10, 10, 1'b1);
      step(449, 161, 1'b1);
      step(97, 193, 1'b1);
      #3 reset = 1'b0;
      #1;
      chk("t1_color", 32'(pixel_color), 32'h00);
      chk("t1_valid", 32'(pixel_valid), 32'h0);
      chk("t1_sel", 32'(cell_sel), 32'h0);
      chk("t1_col", 32'(cell_col), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      pix_en = 1'b0;
      probe("t1_release", 10, 10, 8'hFF, 1'b1);

      // T2: enemy cell codes and address
      board[0][1][1] = 3'd6;
      step(97, 193, 1'b1);
      step(10, 10, 1'b0);
      chk("t2_sel", 32'(cell_sel), 32'h0);
      chk("t2_row", 32'(cell_row), 32'h1);
      chk("t2_col", 32'(cell_col), 32'h1);
      step(10, 10, 1'b1);
      step(10, 10, 1'b0);
      chk("t2_hit", 32'(pixel_color), 32'hB0);
      board[0][1][1] = 3'd3;
      probe("t2_hidden", 97, 193, 8'h1F, 1'b1);
      board[0][4][4] = 3'd7;
      probe("t2_miss", 197, 295, 8'hF0, 1'b1);
      board[1][2][3] = 3'd6;
      probe("t2_phit", 522, 234, 8'hB0, 1'b1);
      board[1][4][4] = 3'd5;
      probe("t2_pship", 564, 308, 8'h92, 1'b1);

      // T3: grid, separator, background, off-screen and board edges
      board[1][0][1] = 3'd2;
      probe("t3_grid", 448, 160, 8'h00, 1'b1);
      probe("t3_pcell", 449, 161, 8'h92, 1'b1);
      probe("t3_sep", 300, 50, 8'h00, 1'b1);
      probe("t3_off", 700, 50, 8'h00, 1'b0);
      probe("t3_e_right", 223, 200, 8'h1F, 1'b1);
      probe("t3_e_past", 224, 200, 8'hFF, 1'b1);
      probe("t3_e_left", 63, 200, 8'hFF, 1'b1);
      probe("t3_sep_hi", 351, 10, 8'h00, 1'b1);
      probe("t3_sep_past", 352, 10, 8'hFF, 1'b1);
      probe("t3_e_bottom", 100, 319, 8'h1F, 1'b1);
      probe("t3_e_below", 100, 320, 8'hFF, 1'b1);
      probe("t3_corner", 639, 479, 8'hFF, 1'b1);
      probe("t3_off_y", 5, 480, 8'h00, 1'b0);

      // T4: cursor blink
      cursor_x = 3'd2;
      cursor_y = 3'd3;
      cursor_en = 1'b0;
      repeat (15) step(0, 0, 1'b1);
      cursor_en = 1'b1;
      repeat (BF - 16) step(0, 0, 1'b1);
      repeat (3) step(0, 0, 1'b0);
      probe("t4_pre", 130, 261, 8'h1F, 1'b1);
      step(0, 0, 1'b1);
      probe("t4_on", 130, 261, 8'hFC, 1'b1);
      probe("t4_ring", 159, 287, 8'hFC, 1'b1);
      probe("t4_inner", 144, 276, 8'h1F, 1'b1);
      probe("t4_grid", 128, 270, 8'h00, 1'b1);
      cursor_en = 1'b0;
      probe("t4_dis", 130, 261, 8'h1F, 1'b1);
      cursor_en = 1'b1;
      cursor_x = 3'd5;
      probe("t4_oob", 130, 261, 8'h1F, 1'b1);
      probe("t4_oob_edge", 223, 261, 8'h1F, 1'b1);
      cursor_x = 3'd2;
      repeat (BF) step(0, 0, 1'b1);
      probe("t4_off", 130, 261, 8'h1F, 1'b1);

      // T5: pix_en gaps hold the pipeline
      step(10, 10, 1'b1);
      step(10, 10, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(t5_x[i], t5_y[i], t5_en[i]);
         chk("t5_seq", 32'(pixel_color), 32'(t5_exp[i]));
      end
      step(10, 10, 1'b1);
      step(10, 10, 1'b0);

      run_cmp = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
